// File: rtl/interrupt_ack_sequencer_if.sv
// Signal bundle between the PIC acknowledge sequencer and its CPU/resolver/command environment.
// The master drives grants, INTA and EOI commands; the slave is the sequencer itself.
interface interrupt_ack_sequencer_if;
  logic       inta_n;
  logic [7:0] interrupt;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [7:0] in_service_register;
  logic [7:0] clear_irr;
  logic [2:0] priority_rotate;
  logic       ack_busy;

  modport master (
    output inta_n, interrupt, vector_base, auto_eoi, eoi_valid, eoi_specific, eoi_level,
           rotate_on_eoi,
    input  int_out, data_out, data_out_en, in_service_register, clear_irr, priority_rotate,
           ack_busy
  );

  modport slave (
    input  inta_n, interrupt, vector_base, auto_eoi, eoi_valid, eoi_specific, eoi_level,
           rotate_on_eoi,
    output int_out, data_out, data_out_en, in_service_register, clear_irr, priority_rotate,
           ack_busy
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// CPU-facing end of the PIC: drives INT, runs the two-pulse INTA acknowledge, owns the ISR,
// returns the vector byte and handles EOI/AEOI with optional priority rotation.
module interrupt_ack_sequencer #(
  parameter int unsigned INTA_SYNC_STAGES = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  interrupt_ack_sequencer_if.slave bus
);

  localparam int unsigned Stages = (INTA_SYNC_STAGES < 2) ? 2 : INTA_SYNC_STAGES;

  typedef enum logic [2:0] {StIdle, StPend, StAck1, StWait2, StAck2} state_e;

  state_e            state_q, state_d;
  logic [Stages-1:0] sync_q;
  logic              inta_prev_q;
  logic [2:0]        lvl_q, lvl_d;
  logic              spurious_q, spurious_d;
  logic              int_out_q, int_out_d;
  logic [7:0]        data_q, data_d;
  logic              data_en_q, data_en_d;
  logic [7:0]        isr_q, isr_d;
  logic [7:0]        clr_irr_q, clr_irr_d;
  logic [2:0]        rot_q, rot_d;

  logic       inta_s, inta_fall, inta_rise;
  logic [2:0] grant_lvl;
  logic [2:0] ns_lvl, ns_idx;
  logic       ns_found;
  logic [7:0] isr_set, isr_clr;

  assign inta_s    = sync_q[Stages-1];
  assign inta_fall = inta_prev_q & ~inta_s;
  assign inta_rise = ~inta_prev_q & inta_s;

  always_comb begin
    grant_lvl = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.interrupt[i]) grant_lvl = 3'(i);
    end
  end

  // Non-specific EOI searches the pre-set ISR starting at the current highest-priority level.
  always_comb begin
    ns_lvl   = 3'd0;
    ns_idx   = 3'd0;
    ns_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ns_idx = rot_q + 3'(i);
      if (!ns_found && isr_q[ns_idx]) begin
        ns_found = 1'b1;
        ns_lvl   = ns_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    spurious_d = spurious_q;
    int_out_d  = int_out_q;
    data_d     = data_q;
    data_en_d  = data_en_q;
    clr_irr_d  = 8'h00;
    rot_d      = rot_q;
    isr_set    = 8'h00;
    isr_clr    = 8'h00;

    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        isr_clr[bus.eoi_level] = 1'b1;
        if (bus.rotate_on_eoi) rot_d = bus.eoi_level + 3'd1;
      end else if (ns_found) begin
        isr_clr[ns_lvl] = 1'b1;
        if (bus.rotate_on_eoi) rot_d = ns_lvl + 3'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.interrupt != 8'h00) begin
          state_d   = StPend;
          int_out_d = 1'b1;
        end
      end
      StPend: begin
        if (inta_fall) begin
          state_d   = StAck1;
          int_out_d = 1'b0;
          if (bus.interrupt == 8'h00) begin
            // Grant withdrawn before INTA1: answer with level 7 and leave ISR/IRR alone.
            lvl_d      = 3'd7;
            spurious_d = 1'b1;
          end else begin
            lvl_d              = grant_lvl;
            spurious_d         = 1'b0;
            isr_set[grant_lvl] = 1'b1;
            clr_irr_d[grant_lvl] = 1'b1;
          end
        end
      end
      StAck1: begin
        if (inta_rise) state_d = StWait2;
      end
      StWait2: begin
        if (inta_fall) begin
          state_d   = StAck2;
          data_d    = {bus.vector_base, lvl_q};
          data_en_d = 1'b1;
        end
      end
      StAck2: begin
        if (inta_rise) begin
          state_d   = StIdle;
          data_d    = 8'h00;
          data_en_d = 1'b0;
          if (bus.auto_eoi && !spurious_q) begin
            isr_clr[lvl_q] = 1'b1;
            if (bus.rotate_on_eoi) rot_d = lvl_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A set in the same cycle as a clear of the same bit wins.
    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      inta_prev_q <= 1'b1;
      state_q     <= StIdle;
      lvl_q       <= 3'd0;
      spurious_q  <= 1'b0;
      int_out_q   <= 1'b0;
      data_q      <= 8'h00;
      data_en_q   <= 1'b0;
      isr_q       <= 8'h00;
      clr_irr_q   <= 8'h00;
      rot_q       <= 3'd0;
    end else begin
      sync_q      <= {sync_q[Stages-2:0], bus.inta_n};
      inta_prev_q <= inta_s;
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      spurious_q  <= spurious_d;
      int_out_q   <= int_out_d;
      data_q      <= data_d;
      data_en_q   <= data_en_d;
      isr_q       <= isr_d;
      clr_irr_q   <= clr_irr_d;
      rot_q       <= rot_d;
    end
  end

  assign bus.int_out             = int_out_q;
  assign bus.data_out            = data_q;
  assign bus.data_out_en         = data_en_q;
  assign bus.in_service_register = isr_q;
  assign bus.clear_irr           = clr_irr_q;
  assign bus.priority_rotate     = rot_q;
  assign bus.ack_busy            = (state_q != StIdle);

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: INTA sequencing, vectors, EOI/AEOI, rotation,
// spurious handling, same-cycle set/clear and mid-sequence reset.
module tb_interrupt_ack_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  interrupt_ack_sequencer_if bus_if ();

  interrupt_ack_sequencer #(
    .INTA_SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the INTA pin; the edge takes effect S+1 = 3 clocks later.
  task automatic pin(input logic val);
    bus_if.inta_n = val;
    repeat (3) @(negedge clk);
  endtask

  task automatic eoi(input logic specific, input logic [2:0] level, input logic rot);
    bus_if.eoi_valid     = 1'b1;
    bus_if.eoi_specific  = specific;
    bus_if.eoi_level     = level;
    bus_if.rotate_on_eoi = rot;
    @(negedge clk);
    bus_if.eoi_valid     = 1'b0;
  endtask

  task automatic full_ack(input string tag, input logic [7:0] irq, input logic [7:0] exp_vec);
    bus_if.interrupt = irq;
    @(negedge clk);
    pin(1'b0);
    bus_if.interrupt = 8'h00;
    pin(1'b1);
    pin(1'b0);
    check(tag, bus_if.data_out, exp_vec);
    pin(1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.inta_n        = 1'b1;
    bus_if.interrupt     = 8'h00;
    bus_if.vector_base   = 5'b01000;
    bus_if.auto_eoi      = 1'b0;
    bus_if.eoi_valid     = 1'b0;
    bus_if.eoi_specific  = 1'b0;
    bus_if.eoi_level     = 3'd0;
    bus_if.rotate_on_eoi = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_int", {7'd0, bus_if.int_out}, 8'h00);
    check("rst_data", bus_if.data_out, 8'h00);
    check("rst_en", {7'd0, bus_if.data_out_en}, 8'h00);
    check("rst_isr", bus_if.in_service_register, 8'h00);
    check("rst_clr", bus_if.clear_irr, 8'h00);
    check("rst_rot", {5'd0, bus_if.priority_rotate}, 8'h00);
    check("rst_busy", {7'd0, bus_if.ack_busy}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sequence, level 3.
    bus_if.interrupt = 8'h08;
    @(negedge clk);
    check("basic_int", {7'd0, bus_if.int_out}, 8'h01);
    check("basic_busy", {7'd0, bus_if.ack_busy}, 8'h01);
    pin(1'b0);
    check("basic_isr", bus_if.in_service_register, 8'h08);
    check("basic_clr", bus_if.clear_irr, 8'h08);
    check("basic_int0", {7'd0, bus_if.int_out}, 8'h00);
    @(negedge clk);
    check("basic_clr_pulse", bus_if.clear_irr, 8'h00);
    bus_if.interrupt = 8'h00;
    pin(1'b1);
    pin(1'b0);
    check("basic_vec", bus_if.data_out, 8'h43);
    check("basic_en", {7'd0, bus_if.data_out_en}, 8'h01);
    bus_if.vector_base = 5'b11111;
    @(negedge clk);
    check("basic_vec_frozen", bus_if.data_out, 8'h43);
    pin(1'b1);
    check("basic_en_off", {7'd0, bus_if.data_out_en}, 8'h00);
    check("basic_data_off", bus_if.data_out, 8'h00);
    check("basic_isr_kept", bus_if.in_service_register, 8'h08);
    check("basic_idle", {7'd0, bus_if.ack_busy}, 8'h00);

    // Specific EOI, then specific EOI on an empty bit with rotation.
    eoi(1'b1, 3'd3, 1'b0);
    check("seoi_isr", bus_if.in_service_register, 8'h00);
    check("seoi_rot", {5'd0, bus_if.priority_rotate}, 8'h00);
    eoi(1'b1, 3'd4, 1'b1);
    check("seoi_empty_rot", {5'd0, bus_if.priority_rotate}, 8'h05);

    // AEOI with rotation from level 7 wraps to 0.
    bus_if.auto_eoi      = 1'b1;
    bus_if.rotate_on_eoi = 1'b1;
    bus_if.vector_base   = 5'b01000;
    bus_if.interrupt     = 8'h80;
    @(negedge clk);
    pin(1'b0);
    check("aeoi_isr_set", bus_if.in_service_register, 8'h80);
    bus_if.interrupt = 8'h00;
    pin(1'b1);
    pin(1'b0);
    check("aeoi_vec", bus_if.data_out, 8'h47);
    pin(1'b1);
    check("aeoi_isr_clr", bus_if.in_service_register, 8'h00);
    check("aeoi_rot", {5'd0, bus_if.priority_rotate}, 8'h00);
    bus_if.auto_eoi      = 1'b0;
    bus_if.rotate_on_eoi = 1'b0;

    // Spurious: grant withdrawn before INTA1.
    bus_if.vector_base = 5'b11111;
    bus_if.interrupt   = 8'h04;
    @(negedge clk);
    check("spur_int", {7'd0, bus_if.int_out}, 8'h01);
    bus_if.interrupt = 8'h00;
    repeat (2) @(negedge clk);
    check("spur_int_held", {7'd0, bus_if.int_out}, 8'h01);
    pin(1'b0);
    check("spur_isr", bus_if.in_service_register, 8'h00);
    check("spur_clr", bus_if.clear_irr, 8'h00);
    check("spur_int0", {7'd0, bus_if.int_out}, 8'h00);
    pin(1'b1);
    pin(1'b0);
    check("spur_vec", bus_if.data_out, 8'hFF);
    pin(1'b1);
    check("spur_en_off", {7'd0, bus_if.data_out_en}, 8'h00);

    // Set rotation to 2; non-specific EOI on empty ISR must not rotate.
    eoi(1'b1, 3'd1, 1'b1);
    check("rot2", {5'd0, bus_if.priority_rotate}, 8'h02);
    eoi(1'b0, 3'd0, 1'b1);
    check("nseoi_empty_rot", {5'd0, bus_if.priority_rotate}, 8'h02);

    // Non-specific EOI with ISR=0A, rotate=2 clears level 3.
    full_ack("vec_l1", 8'h02, 8'hF9);
    full_ack("vec_l3", 8'h08, 8'hFB);
    check("isr_0a", bus_if.in_service_register, 8'h0A);
    eoi(1'b0, 3'd0, 1'b0);
    check("nseoi_isr", bus_if.in_service_register, 8'h02);
    check("nseoi_rot", {5'd0, bus_if.priority_rotate}, 8'h02);
    full_ack("vec_l3b", 8'h08, 8'hFB);
    eoi(1'b0, 3'd0, 1'b1);
    check("nseoi_r_isr", bus_if.in_service_register, 8'h02);
    check("nseoi_r_rot", {5'd0, bus_if.priority_rotate}, 8'h04);

    // Specific EOI on the bit being set in the same cycle: set wins.
    bus_if.interrupt = 8'h08;
    @(negedge clk);
    bus_if.inta_n = 1'b0;
    repeat (2) @(negedge clk);
    eoi(1'b1, 3'd3, 1'b0);
    check("sim_same_isr", bus_if.in_service_register, 8'h0A);
    check("sim_same_clr", bus_if.clear_irr, 8'h08);
    bus_if.interrupt = 8'h00;
    pin(1'b1);
    pin(1'b0);
    pin(1'b1);
    eoi(1'b1, 3'd3, 1'b0);
    check("sim_prep_isr", bus_if.in_service_register, 8'h02);

    // Specific EOI on a different bit in the set cycle.
    bus_if.interrupt = 8'h08;
    @(negedge clk);
    bus_if.inta_n = 1'b0;
    repeat (2) @(negedge clk);
    eoi(1'b1, 3'd1, 1'b0);
    check("sim_diff_isr", bus_if.in_service_register, 8'h08);
    bus_if.interrupt = 8'h00;
    pin(1'b1);
    pin(1'b0);
    pin(1'b1);

    // Reset asserted in WAIT2.
    bus_if.interrupt = 8'h01;
    @(negedge clk);
    pin(1'b0);
    check("mid_isr", bus_if.in_service_register, 8'h09);
    bus_if.interrupt = 8'h00;
    pin(1'b1);
    check("mid_busy", {7'd0, bus_if.ack_busy}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid_rst_int", {7'd0, bus_if.int_out}, 8'h00);
    check("mid_rst_en", {7'd0, bus_if.data_out_en}, 8'h00);
    check("mid_rst_isr", bus_if.in_service_register, 8'h00);
    check("mid_rst_rot", {5'd0, bus_if.priority_rotate}, 8'h00);
    check("mid_rst_busy", {7'd0, bus_if.ack_busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.interrupt = 8'h02;
    @(negedge clk);
    check("post_rst_int", {7'd0, bus_if.int_out}, 8'h01);
    pin(1'b0);
    check("post_rst_isr", bus_if.in_service_register, 8'h02);
    bus_if.interrupt = 8'h00;
    pin(1'b1);
    pin(1'b0);
    check("post_rst_vec", bus_if.data_out, 8'hF9);
    pin(1'b1);
    check("post_rst_idle", {7'd0, bus_if.ack_busy}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
